// File: rtl/gps_sim_pkg.sv
// rtl/gps_sim_pkg.sv - shared constants, G2 phase-selector table and sum-width helper
package gps_sim_pkg;

  localparam int         CA_LEN    = 1023;
  // Tap masks use bit (stage-1): G1 = stages 3,10; G2 = stages 2,3,6,8,9,10
  localparam logic [9:0] G1_TAPS   = 10'h204;
  localparam logic [9:0] G2_TAPS   = 10'h3A6;
  localparam logic [9:0] LFSR_INIT = 10'h3FF;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
  } g2_sel_t;

  function automatic g2_sel_t g2_sel(input logic [5:0] prn);
    case (prn)
      6'd1:  return '{4'd2, 4'd6};
      6'd2:  return '{4'd3, 4'd7};
      6'd3:  return '{4'd4, 4'd8};
      6'd4:  return '{4'd5, 4'd9};
      6'd5:  return '{4'd1, 4'd9};
      6'd6:  return '{4'd2, 4'd10};
      6'd7:  return '{4'd1, 4'd8};
      6'd8:  return '{4'd2, 4'd9};
      6'd9:  return '{4'd3, 4'd10};
      6'd10: return '{4'd2, 4'd3};
      6'd11: return '{4'd3, 4'd4};
      6'd12: return '{4'd5, 4'd6};
      6'd13: return '{4'd6, 4'd7};
      6'd14: return '{4'd7, 4'd8};
      6'd15: return '{4'd8, 4'd9};
      6'd16: return '{4'd9, 4'd10};
      6'd17: return '{4'd1, 4'd4};
      6'd18: return '{4'd2, 4'd5};
      6'd19: return '{4'd3, 4'd6};
      6'd20: return '{4'd4, 4'd7};
      6'd21: return '{4'd5, 4'd8};
      6'd22: return '{4'd6, 4'd9};
      6'd23: return '{4'd1, 4'd3};
      6'd24: return '{4'd4, 4'd6};
      6'd25: return '{4'd5, 4'd7};
      6'd26: return '{4'd6, 4'd8};
      6'd27: return '{4'd7, 4'd9};
      6'd28: return '{4'd8, 4'd10};
      6'd29: return '{4'd1, 4'd6};
      6'd30: return '{4'd2, 4'd7};
      6'd31: return '{4'd3, 4'd8};
      6'd32: return '{4'd4, 4'd9};
      default: return '{4'd1, 4'd1};
    endcase
  endfunction

  function automatic int sum_width(input int n_ch);
`ifdef GPS_SIM_NOISE_EN
    return $clog2(n_ch + 1) + 2;
`else
    return $clog2(n_ch + 1) + 1;
`endif
  endfunction

endpackage

// File: rtl/gps_sim_channel.sv
// rtl/gps_sim_channel.sv - one satellite channel: code/carrier NCOs, Gold generator, epoch counters, nav FIFO
module gps_sim_channel
  import gps_sim_pkg::*;
#(
  parameter int NCO_W          = 32,
  parameter int NAV_DEPTH      = 8,
  parameter int EPOCHS_PER_BIT = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic             cfg_en,
  input  logic [5:0]       cfg_prn,
  input  logic [NCO_W-1:0] cfg_code_fcw,
  input  logic [NCO_W-1:0] cfg_carr_fcw,
  input  logic             push,
  input  logic             push_bit,
  output logic             full,
  output logic             act,
  output logic             tap_d,
  output logic             tap,
  output logic             epoch,
  output logic             underrun
);

  localparam int PW = $clog2(NAV_DEPTH);
  localparam int EW = (EPOCHS_PER_BIT > 1) ? $clog2(EPOCHS_PER_BIT) : 1;

  logic             en;
  logic [5:0]       prn;
  logic [NCO_W-1:0] code_fcw, carr_fcw, code_acc, carr_acc;
  logic [9:0]       g1, g2, chip;
  logic [EW-1:0]    ep_cnt;
  logic             nav_cur;
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             mem [NAV_DEPTH];

  g2_sel_t    sel;
  logic [3:0] i1, i2;
  logic [NCO_W:0] code_nxt;
  logic       carry, wrap, pop, empty, chip_bit;

  always_comb begin
    sel      = g2_sel(prn);
    i1       = sel.s1 - 4'd1;
    i2       = sel.s2 - 4'd1;
    act      = en && (prn >= 6'd1) && (prn <= 6'd32);
    chip_bit = g1[9] ^ g2[i1] ^ g2[i2];
    code_nxt = {1'b0, code_acc} + {1'b0, code_fcw};
    carry    = code_nxt[NCO_W];
    wrap     = carry && (chip == 10'(CA_LEN - 1));
    pop      = wrap && (ep_cnt == EW'(EPOCHS_PER_BIT - 1));
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    tap_d    = act & (nav_cur ^ chip_bit ^ carr_acc[NCO_W-1]);
  end

  // Storage carries no reset; occupancy lives entirely in the pointers
  always_ff @(posedge clk)
    if (push && !cfg_we) mem[wr_ptr[PW-1:0]] <= push_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en <= 1'b0; prn <= '0; code_fcw <= '0; carr_fcw <= '0;
      code_acc <= '0; carr_acc <= '0; g1 <= LFSR_INIT; g2 <= LFSR_INIT;
      chip <= '0; ep_cnt <= '0; nav_cur <= 1'b0; wr_ptr <= '0; rd_ptr <= '0;
      tap <= 1'b0; epoch <= 1'b0; underrun <= 1'b0;
    end else begin
      tap   <= tap_d;
      epoch <= act && wrap && !cfg_we;
      if (cfg_we) begin
        en <= cfg_en; prn <= cfg_prn; code_fcw <= cfg_code_fcw; carr_fcw <= cfg_carr_fcw;
        code_acc <= '0; carr_acc <= '0; g1 <= LFSR_INIT; g2 <= LFSR_INIT;
        chip <= '0; ep_cnt <= '0; nav_cur <= 1'b0; wr_ptr <= '0; rd_ptr <= '0;
        underrun <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (act) begin
          code_acc <= code_nxt[NCO_W-1:0];
          carr_acc <= carr_acc + carr_fcw;
          if (wrap) begin
            chip <= '0; g1 <= LFSR_INIT; g2 <= LFSR_INIT;
            if (pop) begin
              ep_cnt <= '0;
              if (empty) underrun <= 1'b1;
              else begin
                nav_cur <= mem[rd_ptr[PW-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
              end
            end else begin
              ep_cnt <= ep_cnt + 1'b1;
            end
          end else if (carry) begin
            chip <= chip + 10'd1;
            g1   <= {g1[8:0], ^(g1 & G1_TAPS)};
            g2   <= {g2[8:0], ^(g2 & G2_TAPS)};
          end
        end
      end
    end
  end

endmodule

// File: rtl/gps_multich_sim.sv
// rtl/gps_multich_sim.sv - multi-channel GPS L1 C/A stimulus top: channel array and signed composite sum
// Optional dither LFSR on the sum enabled by `define GPS_SIM_NOISE_EN.
module gps_multich_sim
  import gps_sim_pkg::*;
#(
  parameter  int N_CH           = 4,
  parameter  int NCO_W          = 32,
  parameter  int NAV_DEPTH      = 8,
  parameter  int EPOCHS_PER_BIT = 20,
  localparam int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int SUM_W          = sum_width(N_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic                    cfg_en,
  input  logic [5:0]              cfg_prn,
  input  logic [NCO_W-1:0]        cfg_code_fcw,
  input  logic [NCO_W-1:0]        cfg_carr_fcw,
  input  logic                    nav_valid,
  input  logic [CH_W-1:0]         nav_ch,
  input  logic                    nav_bit,
  output logic                    nav_ready,
  output logic [N_CH-1:0]         ch_tap,
  output logic [N_CH-1:0]         epoch,
  output logic [N_CH-1:0]         underrun,
  output logic signed [SUM_W-1:0] sum
);

  localparam logic signed [SUM_W-1:0] ONE       = 1;
  localparam logic signed [SUM_W-1:0] MINUS_ONE = '1;

  logic [N_CH-1:0]         full, act, tap_d;
  logic signed [SUM_W-1:0] total, dither;

  assign nav_ready = rst && (32'(nav_ch) < N_CH) && !full[nav_ch] &&
                     !(cfg_we && (cfg_ch == nav_ch));

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    gps_sim_channel #(
      .NCO_W(NCO_W), .NAV_DEPTH(NAV_DEPTH), .EPOCHS_PER_BIT(EPOCHS_PER_BIT)
    ) u_ch (
      .clk(clk), .rst(rst),
      .cfg_we(cfg_we && (cfg_ch == CH_W'(i))),
      .cfg_en(cfg_en), .cfg_prn(cfg_prn),
      .cfg_code_fcw(cfg_code_fcw), .cfg_carr_fcw(cfg_carr_fcw),
      .push(nav_valid && nav_ready && (nav_ch == CH_W'(i))),
      .push_bit(nav_bit),
      .full(full[i]), .act(act[i]), .tap_d(tap_d[i]),
      .tap(ch_tap[i]), .epoch(epoch[i]), .underrun(underrun[i])
    );
  end

  // Built from the same next-tap values the channels register, so sum tracks ch_tap
  always_comb begin
    total = '0;
    for (int i = 0; i < N_CH; i++)
      if (act[i]) total = tap_d[i] ? total + MINUS_ONE : total + ONE;
  end

`ifdef GPS_SIM_NOISE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
  assign dither = lfsr[0] ? ONE : MINUS_ONE;
`else
  assign dither = '0;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) sum <= '0;
    else      sum <= total + dither;

endmodule
